// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one f2h_sdram Avalon-MM host port among NUM_CH clients.
// Read bursts are routed back through a FIFO of {channel, length} entries.
module sdram_port_arbiter #(
  parameter int NUM_CH          = 3,
  parameter int ADDR_W          = 29,
  parameter int DATA_W          = 64,
  parameter int BURST_W         = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*BURST_W-1:0]  ch_burstcount,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*DATA_W-1:0]   ch_writedata,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_byteenable,
  output logic [NUM_CH-1:0]          ch_waitrequest,
  output logic [DATA_W-1:0]          ch_readdata,
  output logic [NUM_CH-1:0]          ch_readdatavalid,
  output logic [ADDR_W-1:0]          host_address,
  output logic [BURST_W-1:0]         host_burstcount,
  output logic                       host_read,
  output logic                       host_write,
  output logic [DATA_W-1:0]          host_writedata,
  output logic [DATA_W/8-1:0]        host_byteenable,
  input  logic                       host_waitrequest,
  input  logic [DATA_W-1:0]          host_readdata,
  input  logic                       host_readdatavalid,
  output logic                       err
);

  localparam int IDW = $clog2(NUM_CH);
  localparam int BEW = DATA_W / 8;
  localparam int AW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WR_BURST
  } state_t;

  state_t state, state_nx;

  logic [IDW-1:0]     grant_id, grant_nx;
  logic [IDW-1:0]     rr_ptr, rr_nx;
  logic [BURST_W-1:0] wr_left, wr_left_nx;

  logic [IDW-1:0]     id_mem  [MAX_OUTSTANDING];
  logic [BURST_W-1:0] len_mem [MAX_OUTSTANDING];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [BURST_W-1:0] rd_left;
  logic               rd_active;

  logic               full, empty;
  logic               push, pop, beat;
  logic [BURST_W-1:0] push_len, cur_left;
  logic [IDW-1:0]     head_id;

  logic [NUM_CH-1:0]  req;
  logic               pick_ok;
  logic [IDW-1:0]     pick_id;

  logic [ADDR_W-1:0]  sel_addr;
  logic [BURST_W-1:0] sel_burst;
  logic [DATA_W-1:0]  sel_wdata;
  logic [BEW-1:0]     sel_be;
  logic               g_rd, g_wr;

  assign empty = (count == '0);
  assign full  = (count == CW'(MAX_OUTSTANDING));

  // Read-only requests wait while no route slot is free.
  assign req = ch_write | (ch_read & {NUM_CH{~full}});

  always_comb begin : pick_blk
    logic [IDW:0] s;
    s       = '0;
    pick_ok = 1'b0;
    pick_id = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (s >= (IDW+1)'(NUM_CH)) s = s - (IDW+1)'(NUM_CH);
      if (!pick_ok && req[s[IDW-1:0]]) begin
        pick_ok = 1'b1;
        pick_id = s[IDW-1:0];
      end
    end
  end

  assign sel_addr  = ch_address[int'(grant_id)*ADDR_W +: ADDR_W];
  assign sel_burst = ch_burstcount[int'(grant_id)*BURST_W +: BURST_W];
  assign sel_wdata = ch_writedata[int'(grant_id)*DATA_W +: DATA_W];
  assign sel_be    = ch_byteenable[int'(grant_id)*BEW +: BEW];
  assign g_rd      = ch_read[grant_id];
  assign g_wr      = ch_write[grant_id];
  assign push_len  = (sel_burst == '0) ? BURST_W'(1) : sel_burst;

  always_comb begin
    state_nx        = state;
    grant_nx        = grant_id;
    rr_nx           = rr_ptr;
    wr_left_nx      = wr_left;
    push            = 1'b0;
    host_address    = '0;
    host_burstcount = '0;
    host_read       = 1'b0;
    host_write      = 1'b0;
    host_writedata  = '0;
    host_byteenable = '0;
    ch_waitrequest  = '1;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          grant_nx = pick_id;
          rr_nx    = (pick_id == IDW'(NUM_CH-1)) ? '0 : pick_id + IDW'(1);
          state_nx = GRANT;
        end
      end
      GRANT: begin
        host_address             = sel_addr;
        host_burstcount          = sel_burst;
        host_writedata           = sel_wdata;
        host_byteenable          = sel_be;
        host_write               = g_wr;
        host_read                = g_rd & ~g_wr;
        ch_waitrequest[grant_id] = host_waitrequest;
        if (!g_rd && !g_wr) begin
          state_nx = IDLE;
        end else if (!host_waitrequest) begin
          if (g_wr) begin
            if (sel_burst <= BURST_W'(1)) begin
              state_nx = IDLE;
            end else begin
              wr_left_nx = sel_burst - BURST_W'(1);
              state_nx   = WR_BURST;
            end
          end else begin
            push     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      WR_BURST: begin
        host_address             = sel_addr;
        host_burstcount          = sel_burst;
        host_writedata           = sel_wdata;
        host_byteenable          = sel_be;
        host_write               = g_wr;
        ch_waitrequest[grant_id] = host_waitrequest;
        if (g_wr && !host_waitrequest) begin
          wr_left_nx = wr_left - BURST_W'(1);
          if (wr_left <= BURST_W'(1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Return path: the head length is used directly on the first beat of a burst.
  assign head_id  = id_mem[rd_ptr];
  assign beat     = host_readdatavalid & ~empty;
  assign cur_left = rd_active ? rd_left : len_mem[rd_ptr];
  assign pop      = beat & (cur_left <= BURST_W'(1));

  always_comb begin
    ch_readdatavalid = '0;
    ch_readdata      = '0;
    if (beat) begin
      ch_readdatavalid[head_id] = 1'b1;
      ch_readdata               = host_readdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      wr_left   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_left   <= '0;
      rd_active <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_nx;
      grant_id <= grant_nx;
      rr_ptr   <= rr_nx;
      wr_left  <= wr_left_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (beat) begin
        rd_active <= ~pop;
        rd_left   <= pop ? '0 : cur_left - BURST_W'(1);
      end
      if (host_readdatavalid && empty) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr]  <= grant_id;
      len_mem[wr_ptr] <= push_len;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: arbitration order, write locking,
// read routing, route FIFO backpressure and asynchronous reset.
module tb_sdram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int MO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*AW-1:0]   ch_address;
  logic [N*BW-1:0]   ch_burstcount;
  logic [N-1:0]      ch_read;
  logic [N-1:0]      ch_write;
  logic [N*DW-1:0]   ch_writedata;
  logic [N*DW/8-1:0] ch_byteenable;
  logic [N-1:0]      ch_waitrequest;
  logic [DW-1:0]     ch_readdata;
  logic [N-1:0]      ch_readdatavalid;
  logic [AW-1:0]     host_address;
  logic [BW-1:0]     host_burstcount;
  logic              host_read;
  logic              host_write;
  logic [DW-1:0]     host_writedata;
  logic [DW/8-1:0]   host_byteenable;
  logic              host_waitrequest;
  logic [DW-1:0]     host_readdata;
  logic              host_readdatavalid;
  logic              err;

  int n_run  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  logic [63:0] cmd_log [$];
  int          cmd_cyc [$];
  logic [N-1:0] rv_log [$];
  logic [63:0] rd_log  [$];

  int ea [6] = '{'h10, 'h11, 'h12, 'h20, 'h32, 'h30};
  int er [6] = '{1, 2, 4, 1, 4, 1};
  int ei [5] = '{4, 4, 1, 1, 1};

  sdram_port_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW),
    .BURST_W(BW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ch_address        (ch_address),
    .ch_burstcount     (ch_burstcount),
    .ch_read           (ch_read),
    .ch_write          (ch_write),
    .ch_writedata      (ch_writedata),
    .ch_byteenable     (ch_byteenable),
    .ch_waitrequest    (ch_waitrequest),
    .ch_readdata       (ch_readdata),
    .ch_readdatavalid  (ch_readdatavalid),
    .host_address      (host_address),
    .host_burstcount   (host_burstcount),
    .host_read         (host_read),
    .host_write        (host_write),
    .host_writedata    (host_writedata),
    .host_byteenable   (host_byteenable),
    .host_waitrequest  (host_waitrequest),
    .host_readdata     (host_readdata),
    .host_readdatavalid(host_readdatavalid),
    .err               (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int bc, input int a);
    return {27'd0, 8'(bc), 29'(a)};
  endfunction

  function automatic logic [63:0] wd(input int b);
    return 64'hA5A5_0000_0000_0000 | 64'(b);
  endfunction

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] i, input int a, input int bc);
    ch_address[i*AW +: AW]    = AW'(a);
    ch_burstcount[i*BW +: BW] = BW'(bc);
    ch_read[i]                = 1'b1;
  endtask

  // One cycle of the client/host model; accepted reads are dropped.
  task automatic cyc();
    logic [N-1:0] acc;
    #1;
    if (host_read && !host_waitrequest) begin
      cmd_log.push_back({27'd0, host_burstcount, host_address});
      cmd_cyc.push_back(cyc_n);
    end
    if (ch_readdatavalid != '0) begin
      rv_log.push_back(ch_readdatavalid);
      rd_log.push_back(ch_readdata);
    end
    acc = ~ch_waitrequest & ch_read & ~ch_write & {N{host_read}};
    nxt();
    cyc_n++;
    ch_read = ch_read & ~acc;
  endtask

  task automatic run(input int lim);
    int n = 0;
    while (ch_read != '0 && n < lim) begin
      cyc();
      n++;
    end
    chk("run_done", 64'(ch_read), 0);
  endtask

  task automatic ret(input int beats, input logic [63:0] base);
    for (int k = 0; k < beats; k++) begin
      host_readdatavalid = 1'b1;
      host_readdata      = base | 64'(k);
      cyc();
    end
    host_readdatavalid = 1'b0;
    host_readdata      = '0;
  endtask

  initial begin
    logic ok_w, ok_s, held;
    int   b, p;
    reset              = 1'b1;
    ch_address         = '0;
    ch_burstcount      = '0;
    ch_read            = '0;
    ch_write           = '0;
    ch_writedata       = '0;
    ch_byteenable      = '1;
    host_waitrequest   = 1'b0;
    host_readdata      = '0;
    host_readdatavalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_host_read", 64'(host_read), 0);
    chk("rst_host_write", 64'(host_write), 0);
    chk("rst_wait", 64'(ch_waitrequest), 7);
    chk("rst_rdv", 64'(ch_readdatavalid), 0);
    chk("rst_addr", 64'(host_address), 0);
    chk("rst_err", 64'(err), 0);
    reset = 1'b0;

    // Round robin: 0,1,2 together, then 0 alone, then 0 and 2.
    rd(0, 'h10, 1);
    rd(1, 'h11, 1);
    rd(2, 'h12, 1);
    run(20);
    rd(0, 'h20, 1);
    run(10);
    rd(0, 'h30, 1);
    rd(2, 'h32, 1);
    run(20);
    chk("rr_count", 64'(cmd_log.size()), 6);
    for (int k = 0; k < 6; k++)
      if (k < cmd_log.size()) chk($sformatf("rr_addr%0d", k), cmd_log[k], mk(1, ea[k]));
    ret(6, 64'h0);
    chk("rr_ret_count", 64'(rv_log.size()), 6);
    for (int k = 0; k < 6; k++)
      if (k < rv_log.size()) chk($sformatf("rr_route%0d", k), 64'(rv_log[k]), 64'(er[k]));

    // Ch1 burst-4 read routed back.
    cmd_log.delete();
    rv_log.delete();
    rd_log.delete();
    rd(1, 'h100, 4);
    run(10);
    chk("b4_cmd", (cmd_log.size() == 1) ? cmd_log[0] : 64'hx, mk(4, 'h100));
    ret(4, 64'hD000_0000_0000_0000);
    chk("b4_beats", 64'(rv_log.size()), 4);
    for (int k = 0; k < 4; k++)
      if (k < rv_log.size()) begin
        chk($sformatf("b4_rdv%0d", k), 64'(rv_log[k]), 2);
        chk($sformatf("b4_data%0d", k), rd_log[k], 64'hD000_0000_0000_0000 | 64'(k));
      end
    chk("err_clear", 64'(err), 0);
    ret(1, 64'hBAD);
    chk("stray_dropped", 64'(rv_log.size()), 4);
    chk("err_sticky", 64'(err), 1);

    // Ch0 write burst 8 locks out ch2 read, including host stalls.
    ch_write[0]               = 1'b1;
    ch_address[0 +: AW]       = AW'('h200);
    ch_burstcount[0 +: BW]    = 8'd8;
    ch_writedata[0 +: DW]     = wd(0);
    #1;
    chk("wr_bubble", 64'(host_write), 0);
    nxt();
    rd(2, 'h300, 1);
    #1;
    chk("wr_first", {31'd0, host_write, 3'd0, host_address}, {31'd0, 1'b1, 3'd0, 29'h200});
    chk("wr_first_wait", 64'(ch_waitrequest), 3'b110);
    nxt();
    b    = 1;
    ok_w = 1'b1;
    ok_s = 1'b1;
    for (int i = 0; i < 9; i++) begin
      host_waitrequest      = (i == 1 || i == 4);
      ch_writedata[0 +: DW] = wd(b);
      #1;
      ok_s &= ch_waitrequest[2];
      ok_w &= host_write && (host_writedata == wd(b)) &&
              (ch_waitrequest[0] == host_waitrequest);
      if (!host_waitrequest) b++;
      nxt();
    end
    host_waitrequest = 1'b0;
    ch_write[0]      = 1'b0;
    chk("wr_beats", 64'(b), 8);
    chk("wr_ch2_stalled", 64'(ok_s), 1);
    chk("wr_data", 64'(ok_w), 1);
    #1;
    chk("wr_end_idle", {host_read, host_write, 1'b0, ch_waitrequest}, {3'b000, 3'b111});
    nxt();
    #1;
    chk("ch2_granted", {31'd0, host_read, 3'd0, host_address}, {31'd0, 1'b1, 3'd0, 29'h300});
    nxt();
    ch_read[2] = 1'b0;
    rv_log.delete();
    ret(1, 64'h3);
    chk("ch2_route", (rv_log.size() == 1) ? 64'(rv_log[0]) : 64'hx, 4);

    // Route FIFO full: ninth read held until the first return beat.
    cmd_log.delete();
    cmd_cyc.delete();
    rv_log.delete();
    for (int k = 0; k < 8; k++) begin
      rd(0, 'h400 + k, 1);
      run(10);
    end
    chk("full_accepted", 64'(cmd_log.size()), 8);
    rd(0, 'h408, 1);
    held = 1'b1;
    repeat (6) begin
      #1;
      held &= ch_waitrequest[0] & ~host_read;
      nxt();
    end
    chk("full_held", 64'(held), 1);
    p = cyc_n;
    ret(1, 64'h0);
    run(10);
    chk("full_ninth", 64'(cmd_log.size()), 9);
    chk("full_latency", (cmd_cyc.size() == 9) ? 64'(cmd_cyc[8] - p) : 64'hx, 2);
    ret(8, 64'h0);
    chk("full_drain", 64'(rv_log.size()), 9);

    // Interleaved bursts: ch2 x2 then ch0 x3.
    rv_log.delete();
    rd(2, 'h600, 2);
    run(10);
    rd(0, 'h700, 3);
    run(10);
    ret(5, 64'h0);
    chk("il_count", 64'(rv_log.size()), 5);
    for (int k = 0; k < 5; k++)
      if (k < rv_log.size()) chk($sformatf("il_route%0d", k), 64'(rv_log[k]), 64'(ei[k]));

    // Asynchronous reset in the middle of a write burst.
    ch_write[0]            = 1'b1;
    ch_address[0 +: AW]    = AW'('h800);
    ch_burstcount[0 +: BW] = 8'd8;
    repeat (4) nxt();
    #1;
    chk("mid_burst_write", 64'(host_write), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_write", 64'(host_write), 0);
    chk("arst_wait", 64'(ch_waitrequest), 7);
    chk("arst_err", 64'(err), 0);
    @(negedge clk);
    ch_write[0] = 1'b0;
    reset       = 1'b0;
    cmd_log.delete();
    rv_log.delete();
    rd(1, 'h500, 1);
    run(10);
    chk("post_rst_cmd", (cmd_log.size() == 1) ? cmd_log[0] : 64'hx, mk(1, 'h500));
    ret(1, 64'h0);
    chk("post_rst_route", (rv_log.size() == 1) ? 64'(rv_log[0]) : 64'hx, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Parametrised N-channel Avalon-MM arbiter in front of one HPS f2h_sdram port.
- Multiplexes NUM_CH client masters onto a single host port with fair round-robin arbitration and write-burst locking.
- Routes pipelined read bursts back to the originating client through an outstanding-read route FIFO.
- Replaces fixed one-client-per-port wiring, so more cores can share the f2h_sdram0/1/2 ports.

Parameters:
NUM_CH, 3, number of client channels (2..8)
ADDR_W, 29, word address width
DATA_W, 64, data width (64 or 128)
BURST_W, 8, burstcount width
MAX_OUTSTANDING, 8, route FIFO depth (power of 2), i.e. maximum read commands in flight

Ports:
clk  in  1  single clock for clients and host port
reset  in  1  asynchronous, active-high
ch_address  in  NUM_CH*ADDR_W  per-channel address, channel i at slice i
ch_burstcount  in  NUM_CH*BURST_W  per-channel burst length
ch_read  in  NUM_CH  per-channel read request
ch_write  in  NUM_CH  per-channel write request
ch_writedata  in  NUM_CH*DATA_W  per-channel write data
ch_byteenable  in  NUM_CH*DATA_W/8  per-channel byte enables
ch_waitrequest  out  NUM_CH  per-channel stall
ch_readdata  out  DATA_W  shared read data bus
ch_readdatavalid  out  NUM_CH  one-hot read data valid
host_address  out  ADDR_W  to f2h_sdram ADDRESS
host_burstcount  out  BURST_W  to f2h_sdram BURSTCOUNT
host_read  out  1  to f2h_sdram READ
host_write  out  1  to f2h_sdram WRITE
host_writedata  out  DATA_W  to f2h_sdram WRITEDATA
host_byteenable  out  DATA_W/8  to f2h_sdram BYTEENABLE
host_waitrequest  in  1  from f2h_sdram WAITREQUEST
host_readdata  in  DATA_W  from f2h_sdram READDATA
host_readdatavalid  in  1  from f2h_sdram READDATAVALID

Behaviour:
- Reset (async, active-high):
  - state IDLE, rr pointer 0, route FIFO empty, beat counters 0.
  - host_read/host_write 0; ch_waitrequest all 1; ch_readdatavalid 0; data outputs 0.
- Request vector: req[i] = ch_read[i] | ch_write[i].
  - A read-only request is masked while the route FIFO is full.
  - Writes are never masked by the FIFO.
- State IDLE:
  - If any unmasked req exists, pick the first index at or after rr_ptr (wrapping modulo NUM_CH).
  - Register grant_id; rr_ptr <= grant_id+1 (wraps); go to GRANT.
  - One bubble cycle per arbitration.
- State GRANT:
  - Host outputs are a combinational pass-through of channel grant_id.
  - ch_waitrequest[grant_id] = host_waitrequest; every other channel sees 1.
  - Read accepted (host_read & !host_waitrequest):
    - push {grant_id, burstcount} to the route FIFO;
    - go to IDLE.
  - Write beat accepted:
    - burstcount <= 1: go to IDLE.
    - otherwise: wr_left <= burstcount-1, go to WR_BURST.
  - Client drops both read and write before acceptance: go to IDLE (abandon, no host command issued).
- State WR_BURST:
  - Grant stays locked to grant_id; host_burstcount is ignored by the host on beats after the first.
  - Each accepted beat decrements wr_left; the beat that takes it to 0 returns to IDLE.
  - Other channels stay stalled for the whole burst.
- Burstcount 0 on a command is treated as 1, both for the FIFO entry and for wr_left.
- Read return path:
  - Head entry {id, len}; rd_left is loaded from len when the head is first used.
  - Each host_readdatavalid drives ch_readdatavalid[id] = 1 and ch_readdata = host_readdata, combinationally (zero added latency).
  - The last beat pops the FIFO.
  - Push and pop in the same cycle while full is legal; count is unchanged.
- host_readdatavalid with an empty FIFO is a protocol error: the beat is dropped and the sticky err flag in a debug register is set.
- Simultaneous read and write asserted by one channel: the write takes priority, and the read remains pending.
- Reset mid-burst or with reads outstanding: all state is discarded immediately. The host port must be reset concurrently.

Test Plan:
- Ch1 read addr 0x100, burst 4; host returns 4 beats D0..D3 → ch_readdatavalid=3'b010 for exactly 4 cycles, ch_readdata=D0..D3, FIFO empty afterwards.
- Ch0, ch1, ch2 assert single reads in the same cycle, rr_ptr=0 → host sees addresses in order ch0, ch1, ch2; then ch0 and ch2 again → order ch2, ch0 (rr_ptr=1 after ch0 resumes rotation).
- Ch0 write burst 8 while ch2 requests read → ch2 waitrequest=1 for all 8 write beats including host stalls; ch2 granted on the cycle after IDLE.
- MAX_OUTSTANDING=8, host withholds readdatavalid, ch0 issues 9 single reads → 8 accepted, 9th held with waitrequest=1; first return beat pops the FIFO → 9th accepted two cycles later.
- Interleaved outstanding reads: ch2 burst 2 then ch0 burst 3 → valid one-hot 100,100,001,001,001 in that order.
- Reset asserted after 3 of 8 write beats → host_write=0 and all ch_waitrequest=1 in the same cycle (async); after release, a fresh ch1 read is granted normally.
